muldiv_sequencer: RTL and testbench

// - Iterative signed MULT/DIV unit with own FSM; fills the HI/LO path the multicycle CPU lacks.
// - Main Control FSM pulses start, holds its state while busy, then writes HI/LO on done.
// - Raises div_zero so Control can route it into the ExCause/EPC exception path.

---
 rtl/muldiv_sequencer_pkg.sv | 14 +
 rtl/muldiv_sequencer_div_step.sv | 21 ++
 rtl/muldiv_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared op and state encodings for the MULT/DIV sequencer
package muldiv_sequencer_pkg;

    localparam logic [1:0] MD_OP_MULT = 2'b00;
    localparam logic [1:0] MD_OP_DIV  = 2'b01;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'b00,
        MD_MULT   = 2'b01,
        MD_DIV    = 2'b10,
        MD_FINISH = 2'b11
    } md_state_t;

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// rtl/muldiv_sequencer_div_step.sv - one restoring division iteration on unsigned magnitudes
module muldiv_sequencer_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    // w_shift < 2*divisor, so the borrow bit alone says whether the subtraction fits
    assign o_qbit  = ~w_diff[WIDTH];
    assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative signed Booth multiply / restoring divide with HI/LO results
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int ACC_W = 2 * WIDTH + 1;

    md_state_t r_state;
    md_state_t w_next_state;

    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [WIDTH-1:0] r_m;
    logic             r_op_div;
    logic             r_sa;
    logic             r_sb;
    logic             r_dz;
    logic             r_fin;
    logic             r_done;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept_mult;
    logic             w_accept_div;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_sum;
    logic [ACC_W-1:0] w_booth_next;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_qbit;
    logic [WIDTH-1:0] w_acc_hi;
    logic [WIDTH-1:0] w_acc_lo;

    assign w_accept_mult = start && (op == MD_OP_MULT);
    assign w_accept_div  = start && (op == MD_OP_DIV);
    assign w_a_abs       = a_in[WIDTH-1] ? -a_in : a_in;
    assign w_b_abs       = b_in[WIDTH-1] ? -b_in : b_in;
    assign w_acc_hi      = r_acc[ACC_W-1:WIDTH+1];
    assign w_acc_lo      = r_acc[WIDTH:1];

    // Booth add/sub carries a guard bit so subtracting the most negative multiplicand cannot overflow
    assign w_a_ext = {w_acc_hi[WIDTH-1], w_acc_hi};
    assign w_m_ext = {r_m[WIDTH-1], r_m};
    always_comb begin
        w_sum = w_a_ext;
        case (r_acc[1:0])
            2'b01:   w_sum = w_a_ext + w_m_ext;
            2'b10:   w_sum = w_a_ext - w_m_ext;
            default: w_sum = w_a_ext;
        endcase
    end
    assign w_booth_next = {w_sum, r_acc[WIDTH:1]};

    muldiv_sequencer_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .i_rem     (w_acc_hi),
        .i_bit     (r_acc[WIDTH]),
        .i_divisor (r_m),
        .o_rem     (w_rem_next),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MD_IDLE: begin
                if (w_accept_mult) begin
                    w_next_state = MD_MULT;
                end else if (w_accept_div) begin
                    w_next_state = (b_in == '0) ? MD_FINISH : MD_DIV;
                end
            end
            MD_MULT, MD_DIV: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = MD_FINISH;
                end
            end
            MD_FINISH: w_next_state = MD_IDLE;
            default:   w_next_state = MD_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != MD_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_m        <= '0;
            r_op_div   <= 1'b0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_dz       <= 1'b0;
            r_fin      <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_fin      <= 1'b0;
            r_done     <= r_fin;
            r_div_zero <= r_fin && r_dz;
            case (r_state)
                MD_IDLE: begin
                    if (w_accept_mult) begin
                        r_acc    <= {{WIDTH{1'b0}}, b_in, 1'b0};
                        r_m      <= a_in;
                        r_op_div <= 1'b0;
                        r_dz     <= 1'b0;
                        r_cnt    <= CNT_W'(WIDTH);
                    end else if (w_accept_div) begin
                        r_acc    <= {{WIDTH{1'b0}}, w_a_abs, 1'b0};
                        r_m      <= w_b_abs;
                        r_op_div <= 1'b1;
                        r_sa     <= a_in[WIDTH-1];
                        r_sb     <= b_in[WIDTH-1];
                        r_dz     <= (b_in == '0);
                        r_cnt    <= CNT_W'(WIDTH);
                    end
                end
                MD_MULT: begin
                    r_acc <= w_booth_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                MD_DIV: begin
                    r_acc <= {w_rem_next, r_acc[WIDTH-1:1], w_qbit, 1'b0};
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                MD_FINISH: begin
                    r_fin <= 1'b1;
                    r_cnt <= '0;
                    if (!r_dz) begin
                        if (r_op_div) begin
                            r_hi <= r_sa ? -w_acc_hi : w_acc_hi;
                            r_lo <= (r_sa ^ r_sb) ? -w_acc_lo : w_acc_lo;
                        end else begin
                            r_hi <= w_acc_hi;
                            r_lo <= w_acc_lo;
                        end
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi_out   = r_hi;
    assign lo_out   = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - randomized and directed checks against an arithmetic reference model
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke);
        longint   sa;
        longint   sb;
        longint   prod;
        longint   quo;
        longint   rem;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        bit       edz;
        int       lat;
        int       bcnt;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        eh  = m_hi;
        el  = m_lo;
        edz = 1'b0;
        if (o == 2'b00) begin
            prod = sa * sb;
            eh   = prod[63:32];
            el   = prod[31:0];
        end else if (b == '0) begin
            edz = 1'b1;
        end else begin
            quo = sa / sb;
            rem = sa % sb;
            eh  = rem[31:0];
            el  = quo[31:0];
        end
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        bcnt  = busy ? 1 : 0;
        lat   = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = poke && (i == 5);
            op    = 2'b01;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) bcnt++;
        end
        start = 1'b0;
        check_eq("latency", 64'(lat), edz ? 64'd2 : 64'(W + 2));
        check_eq("busy_cycles", 64'(bcnt), edz ? 64'd1 : 64'(W + 1));
        check_eq("busy_at_done", 64'(busy), 64'd0);
        check_eq("hi", 64'(hi_out), 64'(eh));
        check_eq("lo", 64'(lo_out), 64'(el));
        check_eq("div_zero", 64'(div_zero), 64'(edz));
        @(negedge clk);
        check_eq("done_pulse", 64'(done), 64'd0);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic run_noop(input logic [1:0] o);
        int seen;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a_in  = $urandom;
        b_in  = $urandom;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_eq("noop_busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check_eq("noop_no_done", 64'(seen), 64'd0);
    endtask

    initial begin
        int seen;
        logic [1:0] ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_dz", 64'(div_zero), 64'd0);
        check_eq("rst_hi", 64'(hi_out), 64'd0);
        check_eq("rst_lo", 64'(lo_out), 64'd0);

        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b01, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op(2'b01, 32'h0000_2211, 32'h0000_0100, 1'b0);
        run_op(2'b01, 32'd5, 32'd0, 1'b0);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b00, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1);
        run_noop(2'b10);
        run_noop(2'b11);

        for (int k = 0; k < 24; k++) begin
            ro = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 9));
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op(ro, ra, rb, k[2]);
        end

        // abort a multiply partway and confirm everything clears with no done
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a_in  = 32'd1234;
        b_in  = 32'd5678;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_hi", 64'(hi_out), 64'd0);
        check_eq("abort_lo", 64'(lo_out), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check_eq("abort_no_done", 64'(seen), 64'd0);
        m_hi = '0;
        m_lo = '0;
        run_op(2'b00, 32'd3, 32'd4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
